// File: rtl/hash_arb_pkg.sv
// Shared types and constants for the two-requester hash lookup arbiter.
package hash_arb_pkg;

   localparam int NUM_REQ   = 2;
   localparam int REQ_CARD  = 0;
   localparam int REQ_HOST  = 1;
   localparam int LUP_REQ_W = 96;
   localparam int LUP_RSP_W = 120;

   typedef logic                 req_id_t;
   typedef logic [LUP_REQ_W-1:0] lup_req_t;
   typedef logic [LUP_RSP_W-1:0] lup_rsp_t;

endpackage

// File: rtl/hash_lookup_arbiter_rid_fifo.sv
// In-order requester-ID FIFO, first-word-fall-through read of a registered memory.
module rid_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_push;
   logic             w_pop;

   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   // Extra pointer MSB separates full from empty when the index bits match
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
   end

   assign count = r_wptr - r_rptr;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (r_wptr == r_rptr);
   assign dout  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/hash_lookup_arbiter.sv
// Round-robin share of the hash-table lookup channel between card and host
// key streams, with in-order steering of responses back to their issuer.
module hash_lookup_arbiter
   import hash_arb_pkg::*;
#(
   parameter int KEY_WIDTH       = 64,
   parameter int REQ_WIDTH       = 96,
   parameter int RSP_WIDTH       = 120,
   parameter int MAX_OUTSTANDING = 16,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                                 axis_clk,
   input  logic                                 axis_rst,
   input  logic [NUM_REQ-1:0]                   s_key_tvalid,
   input  logic [NUM_REQ*KEY_WIDTH-1:0]         s_key_tdata,
   output logic [NUM_REQ-1:0]                   s_key_tready,
   output logic                                 m_lup_req_tvalid,
   output logic [REQ_WIDTH-1:0]                 m_lup_req_tdata,
   input  logic                                 m_lup_req_tready,
   input  logic                                 s_lup_rsp_tvalid,
   input  logic [RSP_WIDTH-1:0]                 s_lup_rsp_tdata,
   output logic                                 s_lup_rsp_tready,
   output logic [NUM_REQ-1:0]                   m_rsp_tvalid,
   output logic [RSP_WIDTH-1:0]                 m_rsp_tdata,
   input  logic [NUM_REQ-1:0]                   m_rsp_tready,
   output logic [NUM_REQ*CNT_WIDTH-1:0]         grant_cnt,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
   output logic                                 err_orphan_rsp
);

   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   logic                                r_req_full;
   logic [KEY_WIDTH-1:0]                r_req_key;
   req_id_t                             r_req_id;
   req_id_t                             r_last_grant;
   logic [NUM_REQ-1:0][CNT_WIDTH-1:0]   r_grant_cnt;
   logic                                r_err_orphan;

   logic [NUM_REQ-1:0] w_grant;
   req_id_t            w_grant_id;
   logic               w_can_accept;
   logic               w_key_hs;
   logic               w_req_hs;
   logic               w_rsp_hs;
   logic [CW:0]        w_inflight;
   logic [CW-1:0]      w_fifo_count;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   req_id_t            w_head_id;

   // Held request counts against the limit so a full FIFO can never be pushed
   assign w_inflight   = {1'b0, w_fifo_count} + (CW+1)'(r_req_full);
   assign w_can_accept = ~axis_rst & (~r_req_full | m_lup_req_tready)
                       & (w_inflight < (CW+1)'(MAX_OUTSTANDING));

   assign w_grant[REQ_CARD] = s_key_tvalid[REQ_CARD] & (~s_key_tvalid[REQ_HOST] |  r_last_grant);
   assign w_grant[REQ_HOST] = s_key_tvalid[REQ_HOST] & (~s_key_tvalid[REQ_CARD] | ~r_last_grant);
   assign w_grant_id        = w_grant[REQ_HOST];

   assign s_key_tready = {NUM_REQ{w_can_accept}} & w_grant;
   assign w_key_hs     = |s_key_tready;
   assign w_req_hs     = r_req_full & m_lup_req_tready;

   assign m_lup_req_tvalid = r_req_full;
   assign m_lup_req_tdata  = REQ_WIDTH'(r_req_key);

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         r_req_full   <= 1'b0;
         r_req_key    <= '0;
         r_req_id     <= 1'b0;
         r_last_grant <= 1'b1;
         r_grant_cnt  <= '0;
         r_err_orphan <= 1'b0;
      end else begin
         if (w_key_hs) begin
            r_req_full                <= 1'b1;
            r_req_key                 <= s_key_tdata[int'(w_grant_id)*KEY_WIDTH +: KEY_WIDTH];
            r_req_id                  <= w_grant_id;
            r_last_grant              <= w_grant_id;
            r_grant_cnt[w_grant_id]   <= r_grant_cnt[w_grant_id] + CNT_WIDTH'(1);
         end else if (w_req_hs) begin
            r_req_full <= 1'b0;
         end
         if (s_lup_rsp_tvalid & w_fifo_empty) r_err_orphan <= 1'b1;
      end
   end

   // Empty FIFO: sink any beat so a stray response cannot wedge the table
   always_comb begin
      m_rsp_tvalid     = '0;
      s_lup_rsp_tready = 1'b0;
      if (!axis_rst) begin
         if (w_fifo_empty) begin
            s_lup_rsp_tready = 1'b1;
         end else begin
            m_rsp_tvalid[w_head_id] = s_lup_rsp_tvalid;
            s_lup_rsp_tready        = m_rsp_tready[w_head_id];
         end
      end
   end

   assign w_rsp_hs    = s_lup_rsp_tvalid & s_lup_rsp_tready & ~w_fifo_empty;
   assign m_rsp_tdata = s_lup_rsp_tdata;

   rid_fifo #(
      .WIDTH (1),
      .DEPTH (MAX_OUTSTANDING)
   ) u_rid_fifo (
      .clk   (axis_clk),
      .rst   (axis_rst),
      .push  (w_req_hs),
      .pop   (w_rsp_hs),
      .din   (r_req_id),
      .dout  (w_head_id),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (w_fifo_count)
   );

   assign grant_cnt      = r_grant_cnt;
   assign outstanding    = w_fifo_count;
   assign err_orphan_rsp = r_err_orphan;

endmodule
